// File: rtl/alu.sv
// 32-bit RV32I execute-stage ALU with registered result, adder and compare outputs.
module alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [3:0]      io_fn,
  input  logic [XLEN-1:0] io_in1,
  input  logic [XLEN-1:0] io_in2,
  output logic [XLEN-1:0] io_out,
  output logic [XLEN-1:0] io_adder_out,
  output logic            io_cmp_out
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SL   = 4'd1;
  localparam logic [3:0] FN_SEQ  = 4'd2;
  localparam logic [3:0] FN_SNE  = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_SR   = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_AND  = 4'd7;
  localparam logic [3:0] FN_SUB  = 4'd10;
  localparam logic [3:0] FN_SRA  = 4'd11;
  localparam logic [3:0] FN_SLT  = 4'd12;
  localparam logic [3:0] FN_SGE  = 4'd13;
  localparam logic [3:0] FN_SLTU = 4'd14;
  localparam logic [3:0] FN_SGEU = 4'd15;

  logic            sub;
  logic [XLEN-1:0] sum;
  logic [SHW-1:0]  shamt;
  logic            eq;
  logic            ltu;
  logic            lts;
  logic            cmp;

  logic [XLEN-1:0] out_d,   out_q;
  logic [XLEN-1:0] adder_d, adder_q;
  logic            cmp_d,   cmp_q;

  // Shared adder/subtractor and compare primitives.
  always_comb begin
    sub   = io_fn[3];
    sum   = io_in1 + (sub ? ~io_in2 : io_in2) + XLEN'(sub);
    shamt = io_in2[SHW-1:0];
    eq    = (io_in1 == io_in2);
    ltu   = (io_in1 < io_in2);
    // Differing signs decide directly; same signs fall back to unsigned order (overflow-safe).
    lts   = (io_in1[XLEN-1] != io_in2[XLEN-1]) ? io_in1[XLEN-1] : ltu;
  end

  // Compare flag selection.
  always_comb begin
    cmp = 1'b0;
    unique case (io_fn)
      FN_SEQ:  cmp = eq;
      FN_SNE:  cmp = ~eq;
      FN_SLT:  cmp = lts;
      FN_SGE:  cmp = ~lts;
      FN_SLTU: cmp = ltu;
      FN_SGEU: cmp = ~ltu;
      default: cmp = 1'b0;
    endcase
  end

  // Result mux; reserved codes produce zero.
  always_comb begin
    out_d   = '0;
    adder_d = sum;
    cmp_d   = cmp;
    unique case (io_fn)
      FN_ADD, FN_SUB:                          out_d = sum;
      FN_SL:                                   out_d = io_in1 << shamt;
      FN_SEQ, FN_SNE, FN_SLT, FN_SGE,
      FN_SLTU, FN_SGEU:                        out_d = XLEN'(cmp);
      FN_XOR:                                  out_d = io_in1 ^ io_in2;
      FN_SR:                                   out_d = io_in1 >> shamt;
      FN_OR:                                   out_d = io_in1 | io_in2;
      FN_AND:                                  out_d = io_in1 & io_in2;
      FN_SRA:                                  out_d = XLEN'($signed(io_in1) >>> shamt);
      default:                                 out_d = '0;
    endcase
  end

  // Output registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      adder_q <= '0;
      cmp_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      adder_q <= adder_d;
      cmp_q   <= cmp_d;
    end
  end

  assign io_out       = out_q;
  assign io_adder_out = adder_q;
  assign io_cmp_out   = cmp_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized vectors against a reference model.
module tb_alu;

  logic        clock;
  logic        reset_n;
  logic [3:0]  io_fn;
  logic [31:0] io_in1;
  logic [31:0] io_in2;
  logic [31:0] io_out;
  logic [31:0] io_adder_out;
  logic        io_cmp_out;

  int errors = 0;
  int checks = 0;

  alu #(.XLEN(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_fn        (io_fn),
    .io_in1       (io_in1),
    .io_in2       (io_in2),
    .io_out       (io_out),
    .io_adder_out (io_adder_out),
    .io_cmp_out   (io_cmp_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model written from the instruction semantics.
  function automatic logic [31:0] ref_adder(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint unsigned r;
    if (fn >= 4'd8) r = longint'(a) - longint'(b);
    else            r = longint'(a) + longint'(b);
    return r[31:0];
  endfunction

  function automatic logic ref_cmp(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (fn)
      4'd2:    return a == b;
      4'd3:    return a != b;
      4'd12:   return sa < sb;
      4'd13:   return sa >= sb;
      4'd14:   return a < b;
      4'd15:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_out(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = b % 32;
    r  = a;
    case (fn)
      4'd0, 4'd10: return ref_adder(fn, a, b);
      4'd1:  begin for (int i = 0; i < int'(sh); i++) r = r * 2; return r; end
      4'd5:  begin for (int i = 0; i < int'(sh); i++) r = r / 2; return r; end
      4'd11: begin for (int i = 0; i < int'(sh); i++) r = {a[31], r[31:1]}; return r; end
      4'd4:  return a ^ b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd2, 4'd3, 4'd12, 4'd13, 4'd14, 4'd15: return {31'd0, ref_cmp(fn, a, b)};
      default: return 32'd0;
    endcase
  endfunction

  // Drive one vector, capture on the next edge, compare all outputs.
  task automatic run(input string tag, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_out);
    @(negedge clock);
    io_fn  = fn;
    io_in1 = a;
    io_in2 = b;
    @(posedge clock);
    #1;
    check({tag, "_out"},   io_out,       exp_out);
    check({tag, "_adder"}, io_adder_out, ref_adder(fn, a, b));
    check({tag, "_cmp"},   {31'd0, io_cmp_out}, {31'd0, ref_cmp(fn, a, b)});
  endtask

  initial begin
    logic [3:0]  fn;
    logic [31:0] a, b;

    reset_n = 1'b0;
    io_fn   = 4'd0;
    io_in1  = 32'd0;
    io_in2  = 32'd0;
    #22;
    check("rst_out",   io_out,       32'd0);
    check("rst_adder", io_adder_out, 32'd0);
    check("rst_cmp",   {31'd0, io_cmp_out}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run("add",      4'd0,  32'd5,          32'd7,          32'd12);
    run("sub",      4'd10, 32'd20,         32'd7,          32'd13);
    run("sub_wrap", 4'd10, 32'd0,          32'd1,          32'hFFFF_FFFF);
    run("add_wrap", 4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0);
    run("sl",       4'd1,  32'd20,         32'd2,          32'd80);
    run("sr",       4'd5,  32'h8000_0000,  32'd4,          32'h0800_0000);
    run("sra",      4'd11, 32'h8000_0000,  32'd4,          32'hF800_0000);
    run("sl_mask",  4'd1,  32'd20,         32'h21,         32'd40);
    run("sl_32",    4'd1,  32'h1234_5678,  32'd32,         32'h1234_5678);
    run("sra_31",   4'd11, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF);
    run("slt",      4'd12, 32'hFFFF_FFFF,  32'd1,          32'd1);
    run("sltu",     4'd14, 32'hFFFF_FFFF,  32'd1,          32'd0);
    run("seq",      4'd2,  32'd9,          32'd9,          32'd1);
    run("sne",      4'd3,  32'd9,          32'd9,          32'd0);
    run("sgeu",     4'd15, 32'd9,          32'd9,          32'd1);
    run("sge",      4'd13, 32'h8000_0000,  32'd1,          32'd0);
    run("slt_ovf",  4'd12, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1);
    run("xor",      4'd4,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0);
    run("or",       4'd6,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0);
    run("and",      4'd7,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000);
    run("rsv8",     4'd8,  32'd100,        32'd30,         32'd0);
    run("rsv9",     4'd9,  32'd100,        32'd30,         32'd0);

    // Asynchronous reset between edges after a nonzero result.
    run("pre_rst",  4'd0,  32'd5,          32'd7,          32'd12);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_out",   io_out,       32'd0);
    check("async_adder", io_adder_out, 32'd0);
    check("async_cmp",   {31'd0, io_cmp_out}, 32'd0);
    #1;
    reset_n = 1'b1;
    run("post_rst", 4'd10, 32'd50,         32'd8,          32'd42);

    for (int n = 0; n < 400; n++) begin
      fn = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (n % 8 == 0) b = a;
      if (n % 16 == 1) a = {a[31], 31'd0};
      run("rand", fn, a, b, ref_out(fn, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the RV32I execute stage.
- Computes the arithmetic, logic, shift and compare result selected by a 4-bit function code.
- Also exports the raw adder result (address generation) and a 1-bit compare flag (branch resolution).
- Outputs are registered: one clock of latency, cleared by an asynchronous active-low reset.

Parameters:
- XLEN, 32, datapath width; shift amount uses the low log2(XLEN) bits of io_in2.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- io_fn  input  4  function select
- io_in1  input  XLEN  operand 1 (rs1/PC)
- io_in2  input  XLEN  operand 2 (rs2/immediate)
- io_out  output  XLEN  registered ALU result
- io_adder_out  output  XLEN  registered adder/subtractor result
- io_cmp_out  output  1  registered compare flag

Behaviour:
- Reset: while reset_n=0, io_out, io_adder_out and io_cmp_out are 0, asynchronously. Release is synchronised by the clock edge; the first capture happens on the first rising edge with reset_n=1.
- Latency: on every rising edge with reset_n=1, all three output registers load values computed from the current io_fn/io_in1/io_in2. There is no enable and no handshake; io_out reflects the inputs from the previous edge.
- Subtract flag: sub = io_fn[3].
- Adder: sum = io_in1 + (sub ? ~io_in2 : io_in2) + sub, modulo 2^32, carry discarded. io_adder_out takes sum for every fn code.
- Shift amount: shamt = io_in2[4:0]; upper bits of io_in2 are ignored for shifts.
- Compare bit cmp:
  - fn 2 SEQ: (io_in1 == io_in2)
  - fn 3 SNE: (io_in1 != io_in2)
  - fn 12 SLT: signed in1 < in2
  - fn 13 SGE: signed in1 >= in2
  - fn 14 SLTU: unsigned in1 < in2
  - fn 15 SGEU: unsigned in1 >= in2
  - all other codes: 0
- Signed less-than handles overflow correctly. Use an operand-sign comparison, not the raw sum sign.
- io_out by io_fn:
  - 0 ADD: sum
  - 1 SL: in1 << shamt
  - 2/3/12/13/14/15: zero-extended cmp
  - 4 XOR: in1 ^ in2
  - 5 SR: logical right shift
  - 6 OR: in1 | in2
  - 7 AND: in1 & in2
  - 10 SUB: sum (= in1 - in2)
  - 11 SRA: arithmetic right shift, sign-filled
  - 8, 9 (reserved): io_out = 0
- io_cmp_out takes cmp.
- Wrap-around: 0xFFFFFFFF + 1 gives 0; 0 - 1 gives 0xFFFFFFFF; no overflow flag.
- Shift of 0 passes in1 through; shift of 31 is legal; in2 = 32 gives shamt 0.
- Reset asserted mid-operation clears all outputs immediately. In-flight results are discarded.
- Inputs are pure combinational into the registers; no X propagation on reserved codes.

Test Plan:
- Reset then ADD: reset_n=0 -> all outputs 0. Release, fn=0, in1=5, in2=7 -> after one edge io_out=12, io_adder_out=12, io_cmp_out=0.
- SUB: fn=10, in1=20, in2=7 -> io_out=13, io_adder_out=13. fn=10, in1=0, in2=1 -> io_out=0xFFFFFFFF.
- Shifts:
  - fn=1, in1=20, in2=2 -> io_out=80
  - fn=5, in1=0x80000000, in2=4 -> 0x08000000
  - fn=11, same operands -> 0xF8000000
  - fn=1, in2=0x21 -> shift by 1
- Compares:
  - fn=12, in1=0xFFFFFFFF, in2=1 -> io_out=1, io_cmp_out=1
  - fn=14, same operands -> 0
  - fn=2, in1=in2=9 -> 1
  - fn=15, in1=in2 -> 1
  - signed overflow case fn=12, in1=0x80000000, in2=0x7FFFFFFF -> 1
- Logic and reserved:
  - fn=4/6/7, in1=0xF0F0F0F0, in2=0xFF00FF00 -> 0x0FF00FF0 / 0xFFF0FFF0 / 0xF000F000
  - fn=8 -> io_out=0, io_adder_out=in1-in2
- Async reset mid-stream: pulse reset_n low between clock edges after a nonzero result -> outputs go 0 without waiting for a clock edge. Next result appears one edge after release.
